hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core, replacing the purely combinational hazard logic. It produces forwarding selects, per-stage stalls and per-stage flushes. It owns a sequencing FSM for the iterative HI/LO divider, so the divider no longer reports its own stall. It also handles data-memory wait states and exception flushes from M, with a fixed priority between all stall sources.

## Interface
- REG_AW, 5: register-address width for every rs/rt/writeReg port
- DIV_CYCLES, 32: busy cycles of the iterative divider, range 1..255
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  REG_AW  source registers in D
- branchD, jumpD, balD  in  1  D-stage branch, jump, and branch-and-link decode
- rsE, rtE, writeRegE  in  REG_AW  E-stage sources and destination
- regWriteE, memToRegE  in  1  E writes a register / E is a load
- divStartE  in  1  div/divu instruction occupies E
- writeRegM  in  REG_AW; regWriteM, memToRegM, hilo_weM  in  1  M-stage destination and controls
- memReqM  in  1  M is issuing a data-memory access
- dataOkM  in  1  data memory completes the M access this cycle
- excM  in  1  exception committed in M
- writeRegW  in  REG_AW; regWriteW, hilo_weW  in  1  W-stage destination and controls
- forwardAD, forwardBD  out  1  D comparator operand from M
- forwardAE, forwardBE, forwardHiloE  out  2  E operand select: 10 = M, 01 = W, 00 = register file
- stallF, stallD, stallE, stallM  out  1  hold the stage register
- flushD, flushE, flushM, flushW  out  1  load a bubble into the stage register
- divBusy  out  1  divider FSM not IDLE
- divDoneE  out  1  divider result valid this cycle; E latches HI/LO

## Operation
- Forwarding is combinational and unaffected by stalls:
  - forwardAE: 10 when rsE≠0, rsE==writeRegM and regWriteM; else 01 for the same conditions against W; else 00. forwardBE is the same using rtE.
  - forwardHiloE: 10 if hilo_weM, else 01 if hilo_weW, else 00.
  - forwardAD/BD: rsD/rtD ≠0, matching writeRegM, with regWriteM.
- Hazard terms:
  - loadUse: memToRegE, writeRegE≠0, and writeRegE equals rsD or rtD.
  - branchHaz: branchD and either (regWriteE, writeRegE≠0, matching rsD/rtD) or (memToRegM, writeRegM≠0, matching rsD/rtD).
  - memWait: memReqM and !dataOkM.
- Divider FSM, state IDLE/BUSY/DONE with an 8-bit down-counter:
  - IDLE→BUSY when divStartE, !excM and !memWait; counter loads DIV_CYCLES-1.
  - BUSY decrements; at counter==0, BUSY→DONE.
  - DONE→IDLE unconditionally. divDoneE=1 only in DONE.
  - divStall = (IDLE and divStartE) or BUSY.
  - memWait freezes the counter and state.
  - excM forces IDLE next cycle from any state.
- Priority, highest first. Every stall/flush bit not listed for the active level is 0.
  1. excM: flushD=flushE=flushM=1; stalls 0.
  2. memWait: stallF=stallD=stallE=stallM=1, flushW=1.
  3. divStall: stallF=stallD=stallE=1, flushM=1.
  4. loadUse or branchHaz: stallF=stallD=1, flushE=1.
  5. Otherwise: flushE = jumpD or (branchD and !balD). Branch-and-link is never flushed.
- Reset (rst=1):
  - All four flushes are 1 and all stalls are 0, regardless of inputs.
  - State goes to IDLE, counter to 0, divBusy=0, divDoneE=0 on the following edge and stay there while rst is held.
  - Forwarding outputs stay combinational.
- REG_AW changes only port widths. The "register 0 never forwards or stalls" rule holds for every width.

## Timing
- Forwarding, stall and flush outputs: zero-cycle combinational from inputs and current state.
- Divide with no interference:
  - Cycle 0: divStartE seen in IDLE, stall.
  - Cycles 1..DIV_CYCLES: BUSY, stall.
  - Cycle DIV_CYCLES+1: DONE, no stall. The div leaves E at the end of this cycle.
  - Total E occupancy: DIV_CYCLES+2 cycles.
- memWait during BUSY: the stall extends one cycle per wait cycle; the counter holds.
- excM during BUSY: the flush occurs the same cycle, IDLE next cycle, and no divDoneE is produced.
- A second div entering E one cycle after DONE restarts from IDLE normally. Back-to-back divides never skip the IDLE-cycle stall.
- rst asserted mid-divide aborts at the next edge. rst deasserted: IDLE with outputs from inputs only.

## Test plan
- Load-use: lw writes r8 in E (memToRegE=1, writeRegE=8), rsD=8 → stallF=stallD=1, flushE=1. Same with writeRegE=0 → no stall.
- Divide, DIV_CYCLES=4: divStartE held from cycle 0 → stallE=1 cycles 0-4, divDoneE=1 only in cycle 5, divBusy=1 cycles 1-5, IDLE in cycle 6.
- Wait during divide: DIV_CYCLES=4, memReqM=1 with dataOkM=0 in cycles 2-3 → stallM=1 and flushW=1 there, divDoneE moves to cycle 7.
- Exception: excM=1 in cycle 2 of a divide → flushD/E/M=1 and stalls 0 that cycle, divBusy=0 in cycle 3, no divDoneE.
- Forwarding priority: rsE=rtE=5, M and W both write r5 → forwardAE=forwardBE=10. Drop regWriteM → 01. hilo_weM=hilo_weW=1 → forwardHiloE=10.
- Branch: branchD=1, balD=0, no hazard → flushE=1. balD=1 → flushE=0. regWriteE with writeRegE=rtD → stallD=1, flushE=1. rst=1 → all flushes 1, stalls 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
// It produces the forwarding selects, the per-stage stall and flush bits, and
// it sequences the iterative HI/LO divider through IDLE/BUSY/DONE.
// Handshake: divStartE requests a divide. The block answers with divDoneE for
// exactly one cycle. divStartE must stay high until that DONE cycle, because
// E is held until then. An exception or reset aborts the divide, and no
// divDoneE follows.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic              balD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeRegE,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              divStartE,
  input  logic [REG_AW-1:0] writeRegM,
  input  logic              regWriteM,
  input  logic              memToRegM,
  input  logic              hilo_weM,
  input  logic              memReqM,
  input  logic              dataOkM,
  input  logic              excM,
  input  logic [REG_AW-1:0] writeRegW,
  input  logic              regWriteW,
  input  logic              hilo_weW,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic [1:0]        forwardHiloE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              divBusy,
  output logic              divDoneE,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic w_load_use;
  logic w_branch_haz;
  logic w_mem_wait;
  logic w_div_stall;
  logic w_e_hits_d;
  logic w_m_hits_d;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_e_hits_d   = (writeRegE != '0) && ((writeRegE == rsD) || (writeRegE == rtD));
  assign w_m_hits_d   = (writeRegM != '0) && ((writeRegM == rsD) || (writeRegM == rtD));
  assign w_load_use   = memToRegE && w_e_hits_d;
  assign w_branch_haz = branchD && ((regWriteE && w_e_hits_d) || (memToRegM && w_m_hits_d));
  assign w_mem_wait   = memReqM && !dataOkM;
  assign w_div_stall  = ((r_state == S_IDLE) && divStartE) || (r_state == S_BUSY);
  assign o_dbg_state  = r_state;

  // Forwarding selects: the M result is newer, so it wins over W.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardHiloE = 2'b00;
    if ((rsE != '0) && regWriteM && (rsE == writeRegM))      forwardAE = 2'b10;
    else if ((rsE != '0) && regWriteW && (rsE == writeRegW)) forwardAE = 2'b01;
    if ((rtE != '0) && regWriteM && (rtE == writeRegM))      forwardBE = 2'b10;
    else if ((rtE != '0) && regWriteW && (rtE == writeRegW)) forwardBE = 2'b01;
    if (hilo_weM)      forwardHiloE = 2'b10;
    else if (hilo_weW) forwardHiloE = 2'b01;
    forwardAD = (rsD != '0) && regWriteM && (rsD == writeRegM);
    forwardBD = (rtD != '0) && regWriteM && (rtD == writeRegM);
  end

  // Divider state and cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Divider next state. An exception aborts the divide, and a memory wait freezes it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (excM) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (!w_mem_wait) begin
      case (r_state)
        S_IDLE: if (divStartE) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
        S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
                else             w_cnt_nxt   = r_cnt - 8'd1;
        S_DONE: w_state_nxt = S_IDLE;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stall and flush bits by fixed priority. Divider status comes from the state only.
  always_comb begin
    {stallF, stallD, stallE, stallM} = 4'b0000;
    {flushD, flushE, flushM, flushW} = 4'b0000;
    divBusy  = (r_state != S_IDLE);
    divDoneE = (r_state == S_DONE);
    if (rst) begin
      {flushD, flushE, flushM, flushW} = 4'b1111;
    end else if (excM) begin
      {flushD, flushE, flushM} = 3'b111;
    end else if (w_mem_wait) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushW = 1'b1;
    end else if (w_div_stall) begin
      {stallF, stallD, stallE} = 3'b111;
      flushM = 1'b1;
    end else if (w_load_use || w_branch_haz) begin
      {stallF, stallD} = 2'b11;
      flushE = 1'b1;
    end else begin
      // A branch-and-link keeps its delay-slot successor, so it is never flushed.
      flushE = jumpD || (branchD && !balD);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic.
// A reference model runs alongside the DUT. Expected outputs are queued, and a monitor pops and compares them.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0, writeRegE = '0, writeRegM = '0, writeRegW = '0;
  logic branchD = 0, jumpD = 0, balD = 0, regWriteE = 0, memToRegE = 0, divStartE = 0;
  logic regWriteM = 0, memToRegM = 0, hilo_weM = 0, memReqM = 0, dataOkM = 0, excM = 0;
  logic regWriteW = 0, hilo_weW = 0;
  logic forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE, forwardHiloE, dbg_state;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, divBusy, divDoneE;

  hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD), .balD(balD),
    .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE), .memToRegE(memToRegE),
    .divStartE(divStartE), .writeRegM(writeRegM), .regWriteM(regWriteM), .memToRegM(memToRegM),
    .hilo_weM(hilo_weM), .memReqM(memReqM), .dataOkM(dataOkM), .excM(excM),
    .writeRegW(writeRegW), .regWriteW(regWriteW), .hilo_weW(hilo_weW),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardHiloE(forwardHiloE), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .divBusy(divBusy), .divDoneE(divDoneE), .o_dbg_state(dbg_state)
  );

  // Clock and reset: the clock is free-running, and rst starts asserted.
  always #5 clk = ~clk;

  // Scoreboard fields: {fwdD[17:16], AE[15:14], BE[13:12], HILO[11:10], stall FDEM[9:6], flush DEMW[5:2], busy/done[1:0]}
  logic [17:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model of the divide: 0 idle, 1 busy, 2 done; remain = BUSY cycles still owed.
  int m_phase = 0;
  int m_remain = 0;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input logic rwm, input logic [AW-1:0] wm,
                                         input logic rww, input logic [AW-1:0] ww);
    if (src != 0 && rwm && src == wm) return 2'b10;
    if (src != 0 && rww && src == ww) return 2'b01;
    return 2'b00;
  endfunction

  // Driver: move to just after the rising edge and park every input at its idle value.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegE = 0; writeRegM = 0; writeRegW = 0;
    branchD = 0; jumpD = 0; balD = 0; regWriteE = 0; memToRegE = 0; divStartE = 0;
    regWriteM = 0; memToRegM = 0; hilo_weM = 0; memReqM = 0; dataOkM = 0; excM = 0;
    regWriteW = 0; hilo_weW = 0;
  endtask

  // Driver: compute the expected response for this cycle's inputs, queue it, and advance the model.
  task automatic commit();
    logic lu, bh, mw, ds, hitE, hitM;
    logic [3:0] st, fl;
    logic [1:0] hl;
    hitE = (writeRegE != 0) && (writeRegE == rsD || writeRegE == rtD);
    hitM = (writeRegM != 0) && (writeRegM == rsD || writeRegM == rtD);
    lu = memToRegE && hitE;
    bh = branchD && ((regWriteE && hitE) || (memToRegM && hitM));
    mw = memReqM && !dataOkM;
    ds = (m_phase == 0 && divStartE) || m_phase == 1;
    st = 4'b0000; fl = 4'b0000;
    if (rst)           fl = 4'b1111;
    else if (excM)     fl = 4'b1110;
    else if (mw)       begin st = 4'b1111; fl = 4'b0001; end
    else if (ds)       begin st = 4'b1110; fl = 4'b0010; end
    else if (lu || bh) begin st = 4'b1100; fl = 4'b0100; end
    else               fl = {1'b0, jumpD || (branchD && !balD), 2'b00};
    hl = hilo_weM ? 2'b10 : (hilo_weW ? 2'b01 : 2'b00);
    exp_q.push_back({(rsD != 0 && regWriteM && rsD == writeRegM), (rtD != 0 && regWriteM && rtD == writeRegM),
                     fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW),
                     fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW),
                     hl, st, fl, (m_phase != 0), (m_phase == 2)});
    if (rst) begin
      m_phase = 0; m_remain = 0;
    end else if (excM) begin
      m_phase = 0;
    end else if (!mw) begin
      if (m_phase == 0) begin
        if (divStartE) begin m_phase = 1; m_remain = DC; end
      end else if (m_phase == 1) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle's outputs are valid at the falling edge, so pop and compare there.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwdD", {2'b00, forwardAD, forwardBD}, {2'b00, e[17:16]});
        chk("fwdAE", {2'b00, forwardAE}, {2'b00, e[15:14]});
        chk("fwdBE", {2'b00, forwardBE}, {2'b00, e[13:12]});
        chk("fwdHilo", {2'b00, forwardHiloE}, {2'b00, e[11:10]});
        chk("stall", {stallF, stallD, stallE, stallM}, e[9:6]);
        chk("flush", {flushD, flushE, flushM, flushW}, e[5:2]);
        chk("div", {2'b00, divBusy, divDoneE}, {2'b00, e[1:0]});
      end
    end
  end

  initial begin
    // Reset for two cycles, with hazard-looking inputs applied to show they are ignored.
    next_cycle(); rst = 1; branchD = 1; memReqM = 1; commit();
    next_cycle(); rst = 1; excM = 1; commit();
    // Load-use on r8, then the same load writing r0.
    next_cycle(); memToRegE = 1; writeRegE = 8; rsD = 8; commit();
    next_cycle(); memToRegE = 1; writeRegE = 0; rsD = 0; commit();
    // Forwarding priority.
    next_cycle(); rsE = 5; rtE = 5; writeRegM = 5; writeRegW = 5; regWriteM = 1; regWriteW = 1; commit();
    next_cycle(); rsE = 5; rtE = 5; writeRegM = 5; writeRegW = 5; regWriteW = 1; commit();
    next_cycle(); hilo_weM = 1; hilo_weW = 1; rsD = 3; writeRegM = 3; regWriteM = 1; commit();
    next_cycle(); hilo_weW = 1; rtD = 6; writeRegM = 6; regWriteM = 1; commit();
    // Branch, branch-and-link, branch hazard, jump, and reset.
    next_cycle(); branchD = 1; commit();
    next_cycle(); branchD = 1; balD = 1; commit();
    next_cycle(); branchD = 1; regWriteE = 1; writeRegE = 9; rtD = 9; commit();
    next_cycle(); branchD = 1; memToRegM = 1; writeRegM = 4; rsD = 4; commit();
    next_cycle(); jumpD = 1; commit();
    next_cycle(); rst = 1; branchD = 1; commit();
    // A plain divide, cycles 0..6.
    for (int c = 0; c < 7; c++) begin
      next_cycle(); divStartE = (c < 6); commit();
    end
    // A divide with a memory wait in cycles 2-3.
    for (int c = 0; c < 9; c++) begin
      next_cycle(); divStartE = (c < 8);
      if (c == 2 || c == 3) memReqM = 1;
      commit();
    end
    // A divide aborted by an exception in cycle 2.
    for (int c = 0; c < 6; c++) begin
      next_cycle(); divStartE = (c < 2); excM = (c == 2); commit();
    end
    // A divide aborted by reset mid-run.
    for (int c = 0; c < 5; c++) begin
      next_cycle(); divStartE = 1; rst = (c == 2); commit();
    end
    // Random traffic with small register numbers so that dependencies are common.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      writeRegE = AW'($urandom_range(0, 3)); writeRegM = AW'($urandom_range(0, 3));
      writeRegW = AW'($urandom_range(0, 3));
      branchD = ($urandom_range(0, 3) == 0); jumpD = ($urandom_range(0, 7) == 0);
      balD = $urandom_range(0, 1); regWriteE = $urandom_range(0, 1);
      memToRegE = ($urandom_range(0, 3) == 0); divStartE = ($urandom_range(0, 2) != 0);
      regWriteM = $urandom_range(0, 1); memToRegM = ($urandom_range(0, 3) == 0);
      hilo_weM = $urandom_range(0, 1); hilo_weW = $urandom_range(0, 1);
      memReqM = $urandom_range(0, 1); dataOkM = ($urandom_range(0, 3) != 0);
      excM = ($urandom_range(0, 39) == 0); regWriteW = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      commit();
    end
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
